// File: rtl/hmmm_mem_responder_if.sv
// hmmm_mem_responder_if: loader and dump byte-stream handshakes between the board side and the responder
interface hmmm_mem_responder_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       dump_req;
  logic       du_valid;
  logic       du_ready;
  logic [7:0] du_data;
  logic       du_last;
  modport master (
    output ld_valid, ld_data, ld_last, dump_req, du_ready,
    input  ld_ready, du_valid, du_data, du_last
  );
  modport slave (
    input  ld_valid, ld_data, ld_last, dump_req, du_ready,
    output ld_ready, du_valid, du_data, du_last
  );
endinterface

// File: rtl/hmmm_mem_responder.sv
// hmmm_mem_responder: 15-bit unified memory behind the HMMM bus, filled from a byte loader; MEM_DUMP_EN adds a memory dump stream
module hmmm_mem_responder #(
  parameter int DEPTH = 256,
  parameter bit LOAD_ON_RESET = 1
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic [7:0] Adr,
  input  logic       MemWrite,
  inout  wire  [6:0] Instr,
  inout  wire  [7:0] MemData2,
  hmmm_mem_responder_if.slave bus,
  output logic       cpu_reset,
  output logic       load_done,
  output logic       err_overflow
);
  typedef enum logic [1:0] {
    LOAD_LO,
    LOAD_HI,
`ifdef MEM_DUMP_EN
    DUMP,
`endif
    RUN
  } state_t;
  state_t state, nxt;
  logic [14:0] mem [DEPTH];
  logic [8:0] ld_ptr;
  logic [7:0] lo;
  logic [14:0] rd;
  logic hs, ovf, drive;
  assign hs = bus.ld_valid && bus.ld_ready;
  assign ovf = ld_ptr >= 9'(DEPTH);
  assign rd = mem[Adr];
  assign drive = state != RUN || !MemWrite;
  assign Instr = drive ? (state == RUN ? rd[14:8] : 7'd0) : 7'bz;
  assign MemData2 = drive ? (state == RUN ? rd[7:0] : 8'd0) : 8'bz;
`ifdef MEM_DUMP_EN
  logic [8:0] du_cnt;
  logic [14:0] du_word;
  logic du_end;
  assign du_word = mem[du_cnt[8:1]];
  assign du_end = du_cnt == 9'(2 * DEPTH - 1);
`else
  logic unused_dump;
  assign unused_dump = bus.dump_req ^ bus.du_ready;
`endif
  // state register; reset restarts loading (or runs directly when loading is disabled)
  always_ff @(posedge ph1)
    state <= reset ? (LOAD_ON_RESET ? LOAD_LO : RUN) : nxt;
  // next state and handshake/status outputs
  always_comb begin
    nxt = state;
    bus.ld_ready = state == LOAD_LO || state == LOAD_HI;
    cpu_reset = state != RUN;
    bus.du_valid = 1'b0;
    bus.du_data = 8'd0;
    bus.du_last = 1'b0;
    case (state)
      LOAD_LO: nxt = hs ? LOAD_HI : LOAD_LO;
      LOAD_HI: nxt = hs ? (bus.ld_last ? RUN : LOAD_LO) : LOAD_HI;
`ifdef MEM_DUMP_EN
      RUN: nxt = bus.dump_req ? DUMP : RUN;
      DUMP: begin
        bus.du_valid = 1'b1;
        bus.du_data = du_cnt[0] ? {1'b0, du_word[14:8]} : du_word[7:0];
        bus.du_last = du_end;
        nxt = bus.du_ready && du_end ? RUN : DUMP;
      end
`endif
      default: nxt = state;
    endcase
  end
  // loader pointer, pending low byte and sticky status; overflowed words leave the pointer parked
  always_ff @(posedge ph1)
    if (reset) begin
      ld_ptr <= '0;
      load_done <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (state == LOAD_LO && hs) lo <= bus.ld_data;
      if (state == LOAD_HI && hs) begin
        ld_ptr <= ovf ? ld_ptr : ld_ptr + 9'd1;
        err_overflow <= err_overflow | ovf;
        load_done <= load_done | bus.ld_last;
      end
    end
  // memory writes: loader words while loading, low-byte stores while running; reset blocks both
  always_ff @(posedge ph1)
    if (!reset && state == LOAD_HI && hs && !ovf) mem[ld_ptr[7:0]] <= {bus.ld_data[6:0], lo};
    else if (!reset && state == RUN && MemWrite) mem[Adr][7:0] <= MemData2;
`ifdef MEM_DUMP_EN
  // dump byte counter: even counts send the low byte, odd counts the high bits
  always_ff @(posedge ph1)
    du_cnt <= reset || state != DUMP ? 9'd0 : du_cnt + 9'(bus.du_ready);
`endif
endmodule

// File: tb/tb_hmmm_mem_responder.sv
// tb_hmmm_mem_responder: randomized load/store/reset scenarios against a word-array model of the memory image
module tb_hmmm_mem_responder;
  logic ph1 = 1'b0;
  logic reset = 1'b1;
  logic [7:0] Adr = 8'd0;
  logic MemWrite = 1'b0;
  wire [6:0] Instr;
  wire [7:0] MemData2;
  logic md_drv = 1'b0;
  logic [7:0] md_val = 8'd0;
  logic cpu_reset, load_done, err_overflow;
  int n_chk = 0;
  int n_fail = 0;
  logic [14:0] mm [256];
  hmmm_mem_responder_if bus();
  assign MemData2 = md_drv ? md_val : 8'bz;
  hmmm_mem_responder #(.DEPTH(256), .LOAD_ON_RESET(1)) dut (
    .ph1(ph1), .reset(reset), .Adr(Adr), .MemWrite(MemWrite), .Instr(Instr), .MemData2(MemData2),
    .bus(bus), .cpu_reset(cpu_reset), .load_done(load_done), .err_overflow(err_overflow)
  );
  always #5 ph1 = ~ph1;
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ld_valid = 1'b0;
    bus.ld_data = 8'($urandom);
    bus.ld_last = 1'($urandom);
    repeat (n) tick();
    bus.ld_last = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    n_chk++;
    if (bus.ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_ready_before_byte: got %b want 1", bus.ld_ready);
    end
    bus.ld_valid = 1'b1;
    bus.ld_data = d;
    bus.ld_last = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
  endtask

  // a word arrives as low byte (ld_last random, it must be ignored) then high byte; bit 15 of w is the ignored ld_data[7]
  task automatic send_word(input logic [15:0] w, input logic last, input int gap);
    idle($urandom_range(0, gap));
    send_byte(w[7:0], 1'($urandom));
    idle($urandom_range(0, gap));
    send_byte(w[15:8], last);
  endtask

  task automatic do_reset();
    bus.ld_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.ld_valid = 1'b1;
    bus.ld_data = 8'hEE;
    bus.ld_last = 1'b1;
    bus.dump_req = 1'b0;
    bus.du_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({cpu_reset, bus.ld_ready, load_done, err_overflow, bus.du_valid} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_flags: got cpu_reset/ld_ready/load_done/err_overflow/du_valid=%b want 11000",
               {cpu_reset, bus.ld_ready, load_done, err_overflow, bus.du_valid});
    end
    n_chk++;
    if ({Instr, MemData2} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_buses: got %h want 0000", {Instr, MemData2});
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] b [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    for (int i = 0; i < 6; i++) begin
      send_byte(b[i], i == 5);
      if (i == 4) begin
        n_chk++;
        if ({cpu_reset, load_done} !== 2'b10) begin
          n_fail++;
          $display("FAIL basic_before_last: got cpu_reset/load_done=%b want 10", {cpu_reset, load_done});
        end
      end
    end
    mm[0] = 15'h3412;
    mm[1] = 15'h7856;
    mm[2] = 15'h3C9A;
    n_chk++;
    if ({load_done, cpu_reset, bus.ld_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_done: got load_done/cpu_reset/ld_ready=%b want 100", {load_done, cpu_reset, bus.ld_ready});
    end
    bus.ld_valid = 1'b1;
    bus.ld_data = 8'h00;
    bus.ld_last = 1'b1;
    repeat (4) tick();
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    for (int a = 0; a < 3; a++) begin
      Adr = 8'(a);
      #1;
      n_chk++;
      if ({Instr, MemData2} !== mm[a]) begin
        n_fail++;
        $display("FAIL basic_read adr=%0d: got %h want %h", a, {Instr, MemData2}, mm[a]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      n_chk++;
      if ({bus.ld_ready, cpu_reset, load_done} !== 3'b110) begin
        n_fail++;
        $display("FAIL stall_cycle %0d: got ld_ready/cpu_reset/load_done=%b want 110", i, {bus.ld_ready, cpu_reset, load_done});
      end
    end
    send_byte(8'hC3, 1'b1);
    mm[0] = 15'h435A;
    n_chk++;
    if ({load_done, cpu_reset} !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_done: got load_done/cpu_reset=%b want 10", {load_done, cpu_reset});
    end
    Adr = 8'd0;
    #1;
    n_chk++;
    if ({Instr, MemData2} !== mm[0]) begin
      n_fail++;
      $display("FAIL stall_word: got %h want %h", {Instr, MemData2}, mm[0]);
    end
  endtask

  task automatic test_full_load();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      send_word(w, i == 255, 2);
      mm[i] = w[14:0];
    end
    n_chk++;
    if ({load_done, err_overflow, cpu_reset} !== 3'b100) begin
      n_fail++;
      $display("FAIL full_flags: got load_done/err_overflow/cpu_reset=%b want 100", {load_done, err_overflow, cpu_reset});
    end
    for (int a = 0; a < 256; a++) begin
      Adr = 8'(a);
      #2;
      n_chk++;
      if ({Instr, MemData2} !== mm[a]) begin
        n_fail++;
        $display("FAIL full_read adr=%0d: got %h want %h", a, {Instr, MemData2}, mm[a]);
      end
    end
  endtask

  task automatic test_store();
    logic [7:0] a, d;
    for (int i = 0; i < 40; i++) begin
      a = i == 0 ? 8'h40 : (i % 5 == 4 ? a : 8'($urandom));
      d = i == 0 ? 8'hA5 : 8'($urandom);
      Adr = a;
      MemWrite = 1'b1;
      md_drv = 1'b1;
      md_val = d;
      #1;
      n_chk++;
      if (MemData2 !== d) begin
        n_fail++;
        $display("FAIL store_bus adr=%h: got %h want %h", a, MemData2, d);
      end
      tick();
      mm[a][7:0] = d;
      if (i % 3 != 2) begin
        MemWrite = 1'b0;
        md_drv = 1'b0;
        #1;
        n_chk++;
        if ({Instr, MemData2} !== mm[a]) begin
          n_fail++;
          $display("FAIL store_read adr=%h: got %h want %h", a, {Instr, MemData2}, mm[a]);
        end
        Adr = 8'($urandom);
        #1;
        n_chk++;
        if ({Instr, MemData2} !== mm[Adr]) begin
          n_fail++;
          $display("FAIL store_other adr=%h: got %h want %h", Adr, {Instr, MemData2}, mm[Adr]);
        end
        tick();
      end
    end
    MemWrite = 1'b0;
    md_drv = 1'b0;
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_byte(8'hFF, 1'b0);
    do_reset();
    send_word(16'h0022 << 8 | 16'h0011, 1'b1, 1);
    mm[0] = 15'h2211;
    for (int a = 0; a < 2; a++) begin
      Adr = 8'(a);
      #1;
      n_chk++;
      if ({Instr, MemData2} !== mm[a]) begin
        n_fail++;
        $display("FAIL midload_read adr=%0d: got %h want %h", a, {Instr, MemData2}, mm[a]);
      end
    end
  endtask

  task automatic test_reset_handshake();
    logic [15:0] wa, wb, wc;
    wa = 16'($urandom);
    wb = ~{1'b0, mm[1]};
    wc = 16'($urandom);
    do_reset();
    send_word(wa, 1'b0, 1);
    send_byte(wb[7:0], 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data = wb[15:8];
    bus.ld_last = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    n_chk++;
    if ({cpu_reset, load_done, bus.ld_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL rsths_flags: got cpu_reset/load_done/ld_ready=%b want 101", {cpu_reset, load_done, bus.ld_ready});
    end
    send_word(wc, 1'b1, 0);
    mm[0] = wc[14:0];
    for (int a = 0; a < 2; a++) begin
      Adr = 8'(a);
      #1;
      n_chk++;
      if ({Instr, MemData2} !== mm[a]) begin
        n_fail++;
        $display("FAIL rsths_read adr=%0d: got %h want %h", a, {Instr, MemData2}, mm[a]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      send_word(w, 1'b0, 1);
      mm[i] = w[14:0];
    end
    n_chk++;
    if ({err_overflow, cpu_reset, load_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL ovf_at_depth: got err_overflow/cpu_reset/load_done=%b want 010", {err_overflow, cpu_reset, load_done});
    end
    send_word(~{1'b0, mm[0]}, 1'b0, 1);
    n_chk++;
    if ({err_overflow, cpu_reset, load_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL ovf_257: got err_overflow/cpu_reset/load_done=%b want 110", {err_overflow, cpu_reset, load_done});
    end
    send_word(~{1'b0, mm[1]}, 1'b1, 1);
    n_chk++;
    if ({err_overflow, cpu_reset, load_done} !== 3'b101) begin
      n_fail++;
      $display("FAIL ovf_done: got err_overflow/cpu_reset/load_done=%b want 101", {err_overflow, cpu_reset, load_done});
    end
    for (int a = 0; a < 256; a++) begin
      Adr = 8'(a);
      #2;
      n_chk++;
      if ({Instr, MemData2} !== mm[a]) begin
        n_fail++;
        $display("FAIL ovf_read adr=%0d: got %h want %h", a, {Instr, MemData2}, mm[a]);
      end
    end
  endtask

  task automatic test_run_reset();
    logic [15:0] w;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if ({cpu_reset, bus.ld_ready, load_done, err_overflow} !== 4'b1100) begin
      n_fail++;
      $display("FAIL run_reset: got cpu_reset/ld_ready/load_done/err_overflow=%b want 1100",
               {cpu_reset, bus.ld_ready, load_done, err_overflow});
    end
    w = 16'($urandom);
    send_word(w, 1'b1, 0);
    mm[0] = w[14:0];
    for (int i = 0; i < 4; i++) begin
      Adr = i == 0 ? 8'd0 : 8'($urandom_range(1, 255));
      #1;
      n_chk++;
      if ({Instr, MemData2} !== mm[Adr]) begin
        n_fail++;
        $display("FAIL run_reset_keep adr=%h: got %h want %h", Adr, {Instr, MemData2}, mm[Adr]);
      end
    end
  endtask

  task automatic test_dump();
`ifdef MEM_DUMP_EN
    logic [15:0] w;
    logic [7:0] exp_b;
    int k = 0;
    int budget = 4000;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      w = 16'($urandom);
      send_word(w, i == 1, 0);
      mm[i] = w[14:0];
    end
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    while (k < 512 && budget > 0) begin
      bus.du_ready = 1'($urandom);
      #1;
      exp_b = k[0] ? {1'b0, mm[k / 2][14:8]} : mm[k / 2][7:0];
      n_chk++;
      if ({cpu_reset, bus.du_valid} !== 2'b11) begin
        n_fail++;
        $display("FAIL dump_flags byte %0d: got cpu_reset/du_valid=%b want 11", k, {cpu_reset, bus.du_valid});
      end
      n_chk++;
      if ({bus.du_data, bus.du_last} !== {exp_b, 1'(k == 511)}) begin
        n_fail++;
        $display("FAIL dump_byte %0d: got data/last=%h/%b want %h/%b", k, bus.du_data, bus.du_last, exp_b, k == 511);
      end
      if (bus.du_ready) k++;
      budget--;
      tick();
    end
    n_chk++;
    if (k !== 512) begin
      n_fail++;
      $display("FAIL dump_count: got %0d bytes want 512", k);
    end
    bus.du_ready = 1'b0;
    n_chk++;
    if ({cpu_reset, bus.du_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL dump_back_to_run: got cpu_reset/du_valid=%b want 00", {cpu_reset, bus.du_valid});
    end
`else
    bus.du_ready = 1'b1;
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({cpu_reset, bus.du_valid, bus.du_last, bus.du_data} !== 11'd0) begin
        n_fail++;
        $display("FAIL dump_disabled cycle %0d: got cpu_reset/du_valid/du_last/du_data=%b want 0",
                 i, {cpu_reset, bus.du_valid, bus.du_last, bus.du_data});
      end
      tick();
    end
    bus.du_ready = 1'b0;
`endif
  endtask

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_data = 8'd0;
    bus.ld_last = 1'b0;
    bus.dump_req = 1'b0;
    bus.du_ready = 1'b0;
    test_reset();
    test_basic_load();
    test_stall();
    test_full_load();
    test_store();
    test_reset_midload();
    test_reset_handshake();
    test_overflow();
    test_run_reset();
    test_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
